ps2_key_decoder: RTL

//  Receives PS/2 keyboard serial frames on ps2_clk/ps2_data and produces the 11-bit ps2_key event word.

---
 rtl/ps2_key_decoder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard receiver producing the 11-bit ps2_key event word (option: PS2_PARITY_CHECK_EN)
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 26000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            clk_filt;
    logic [FW-1:0]   filt_cnt;
    logic            fall;
    logic [TW-1:0]   tcnt_q;
    logic [2:0]      bitcnt_q;
    logic [7:0]      sr_q;
    logic [7:0]      byte_q;
    logic            byte_vld_q;
    logic            ext_q, rel_q;
    logic            timeout;
    logic            accept, err;
    logic            par_ok;

    // Two-flop synchronizers; idle level of both PS/2 lines is high
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Clock deglitch: flip only after FILTER_LEN consecutive differing samples; fall is a 1-cycle pulse
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 != clk_filt) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_filt <= clk_s2;
                    filt_cnt <= '0;
                    fall     <= clk_filt;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic par_q;

    // Parity bit is captured only when it is going to be checked
    always_ff @(posedge clk_sys) begin
        if (reset)
            par_q <= 1'b0;
        else if (fall && state_q == PARITY)
            par_q <= dat_s2;
    end

    assign par_ok = ^{sr_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    // A fall in the same cycle as the limit takes priority over the timeout
    assign timeout = (state_q != IDLE) && !fall && (tcnt_q == TW'(TIMEOUT - 1));

    // Next-state and frame verdict; a timeout aborts any frame in progress
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE:   if (fall && !dat_s2) state_d = DATA;
            DATA:   if (fall && bitcnt_q == 3'd7) state_d = PARITY;
            PARITY: if (fall) state_d = STOP;
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (dat_s2 && par_ok)
                        accept = 1'b1;
                    else
                        err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
            err     = 1'b1;
            accept  = 1'b0;
        end
    end

    // State register, bit shifter and mid-frame timeout counter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            tcnt_q   <= '0;
            bitcnt_q <= 3'd0;
            sr_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE || fall || timeout)
                tcnt_q <= '0;
            else
                tcnt_q <= tcnt_q + 1'b1;
            if (fall) begin
                if (state_q == IDLE)
                    bitcnt_q <= 3'd0;
                else if (state_q == DATA) begin
                    sr_q     <= {dat_s2, sr_q[7:1]};
                    bitcnt_q <= bitcnt_q + 3'd1;
                end
            end
        end
    end

    // Prefix tracking and event word update, one cycle after an accepted stop bit
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            byte_vld_q <= 1'b0;
            byte_q     <= 8'h00;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            ps2_key    <= 11'h000;
            frame_err  <= 1'b0;
        end else begin
            byte_vld_q <= accept;
            if (accept)
                byte_q <= sr_q;
            frame_err <= err;
            if (byte_vld_q) begin
                if (byte_q == 8'hE0)
                    ext_q <= 1'b1;
                else if (byte_q == 8'hF0)
                    rel_q <= 1'b1;
                else begin
                    ps2_key <= {~ps2_key[10], ~rel_q, ext_q, byte_q};
                    ext_q   <= 1'b0;
                    rel_q   <= 1'b0;
                end
            end
            if (err) begin
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end
        end
    end

endmodule
